// File: rtl/hsv_pkg.sv
// hsv_pkg: shared types and helpers for the streaming RGB-to-HSV converter.
// Holds the hue sector enum, channel expansion and the latency arithmetic.
package hsv_pkg;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} sector_t;
  function automatic int q_of(input int hf, input int sf);
    return (hf > sf ? hf : sf) + 1;
  endfunction
  function automatic int l_of(input int hf, input int sf);
    return 3 + q_of(hf, sf);
  endfunction
  localparam int Q = q_of(8, 8);
  localparam int L = l_of(8, 8);
  // Bit replication: the top bits of x refill the vacated LSBs, so full scale stays full scale.
  function automatic logic [31:0] expand(input logic [31:0] x, input int w, input int cw);
    return cw >= w ? (x << (cw - w)) | (x >> (2 * w - cw)) : x >> (w - cw);
  endfunction
endpackage

// File: rtl/hsv_div_pipe.sv
// hsv_div_pipe: enable-gated pipelined restoring divider, o_quo = floor(i_num*2^(Q_W-1)/i_den) for i_num <= i_den.
// Ports: i_clk/i_rstn (sync, active-low), i_en advances all stages, i_valid/i_num/i_den in,
// o_valid/o_quo/o_dz (divide-by-zero flag) out after Q_W cycles.
module hsv_div_pipe #(
  parameter int N_W = 8,
  parameter int D_W = 8,
  parameter int Q_W = 9
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_en,
  input  logic           i_valid,
  input  logic [N_W-1:0] i_num,
  input  logic [D_W-1:0] i_den,
  output logic           o_valid,
  output logic [Q_W-1:0] o_quo,
  output logic           o_dz
);
  logic [D_W-1:0] r_q [Q_W], r_d [Q_W], d_q [Q_W], d_d [Q_W], pr [Q_W], pd [Q_W];
  logic [Q_W-1:0] q_q [Q_W], q_d [Q_W], pq [Q_W];
  logic           v_q [Q_W], v_d [Q_W], z_q [Q_W], z_d [Q_W], pv [Q_W], pz [Q_W], ge [Q_W];
  logic [D_W:0]   t [Q_W];
  // Stage 0 compares the unshifted numerator: it yields the 2^(Q_W-1) bit, set only when num == den.
  always_comb begin
    pr[0] = '0;
    pd[0] = i_den;
    pq[0] = '0;
    pv[0] = i_valid;
    pz[0] = i_den == '0;
    for (int k = 1; k < Q_W; k++) begin
      pr[k] = r_q[k-1];
      pd[k] = d_q[k-1];
      pq[k] = q_q[k-1];
      pv[k] = v_q[k-1];
      pz[k] = z_q[k-1];
    end
    for (int k = 0; k < Q_W; k++) begin
      t[k] = k == 0 ? (D_W+1)'(i_num) : {pr[k], 1'b0};
      ge[k] = t[k] >= {1'b0, pd[k]};
      r_d[k] = D_W'(ge[k] ? t[k] - {1'b0, pd[k]} : t[k]);
      q_d[k] = {pq[k][Q_W-2:0], ge[k]};
      d_d[k] = pd[k];
      v_d[k] = pv[k];
      z_d[k] = pz[k];
    end
  end
  always_ff @(posedge i_clk)
    if (!i_rstn) begin
      r_q <= '{default: '0};
      d_q <= '{default: '0};
      q_q <= '{default: '0};
      v_q <= '{default: 1'b0};
      z_q <= '{default: 1'b0};
    end else if (i_en) begin
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
      v_q <= v_d;
      z_q <= z_d;
    end
  assign o_valid = v_q[Q_W-1];
  assign o_quo   = q_q[Q_W-1];
  assign o_dz    = z_q[Q_W-1];
endmodule

// File: rtl/hsv_stream.sv
// hsv_stream: fully pipelined RGB-to-HSV converter with ready/valid on both sides, latency 3+Q.
// Ports: i_clk, i_rstn (sync, active-low); i_data {R,G,B}, i_user, i_valid, o_ready upstream;
// o_hue, o_sat, o_value, o_user, o_valid, i_ready downstream.
module hsv_stream
  import hsv_pkg::*;
#(
  parameter int R_W    = 5,
  parameter int G_W    = 6,
  parameter int B_W    = 5,
  parameter int CW     = 8,
  parameter int HF     = 8,
  parameter int SF     = 8,
  parameter int USER_W = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [R_W+G_W+B_W-1:0] i_data,
  input  logic [USER_W-1:0]      i_user,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [HF+2:0]          o_hue,
  output logic [SF-1:0]          o_sat,
  output logic [CW-1:0]          o_value,
  output logic [USER_W-1:0]      o_user,
  output logic                   o_valid,
  input  logic                   i_ready
);
  localparam int DW = R_W + G_W + B_W;
  localparam int QN = q_of(HF, SF);
  logic                en, hv, sv, hz, sz;
  logic [CW-1:0]       r, g, b;
  logic [CW-1:0]       r1_q, r1_d, g1_q, g1_d, b1_q, b1_d, mx1_q, mx1_d, mn1_q, mn1_d;
  logic [CW-1:0]       num2_q, num2_d, dl2_q, dl2_d, mx2_q, mx2_d;
  sector_t             sec1_q, sec1_d, sec2_q, sec2_d;
  logic                v1_q, v1_d, v2_q, v2_d, vld_q, vld_d;
  logic [USER_W-1:0]   u1_q, u1_d, u2_q, u2_d, usr_q, usr_d;
  sector_t             sec_q [QN], sec_d [QN];
  logic [CW-1:0]       mx_q [QN], mx_d [QN];
  logic [USER_W-1:0]   us_q [QN], us_d [QN];
  logic [QN-1:0]       hq, sq;
  logic [HF:0]         hfr;
  logic [SF:0]         sfr;
  logic [HF+2:0]       hue_q, hue_d;
  logic [SF-1:0]       sat_q, sat_d;
  logic [CW-1:0]       val_q, val_d;
  always_comb begin
    en = ~vld_q | i_ready;
    r = CW'(expand(32'(i_data[DW-1 -: R_W]), R_W, CW));
    g = CW'(expand(32'(i_data[B_W +: G_W]), G_W, CW));
    b = CW'(expand(32'(i_data[B_W-1:0]), B_W, CW));
    r1_d = r;
    g1_d = g;
    b1_d = b;
    mx1_d = (r >= g && r >= b) ? r : (g >= b) ? g : b;
    mn1_d = (r <= g && r <= b) ? r : (g <= b) ? g : b;
    sec1_d = (r >= g && r >= b) ? (g >= b ? S0 : S5) : (g >= b) ? (r >= b ? S1 : S2) : (g >= r ? S3 : S4);
    v1_d = i_valid;
    u1_d = i_user;
    num2_d = sec1_q == S0 ? g1_q - b1_q : sec1_q == S1 ? g1_q - r1_q : sec1_q == S2 ? b1_q - r1_q :
             sec1_q == S3 ? b1_q - g1_q : sec1_q == S4 ? r1_q - g1_q : r1_q - b1_q;
    dl2_d = mx1_q - mn1_q;
    mx2_d = mx1_q;
    sec2_d = sec1_q;
    v2_d = v1_q;
    u2_d = u1_q;
    sec_d[0] = sec2_q;
    mx_d[0] = mx2_q;
    us_d[0] = u2_q;
    for (int k = 1; k < QN; k++) begin
      sec_d[k] = sec_q[k-1];
      mx_d[k] = mx_q[k-1];
      us_d[k] = us_q[k-1];
    end
    // Dividers produce QN bits of quotient; the top HF+1 / SF+1 bits are the floored results.
    hfr = hq[QN-1 -: HF+1];
    sfr = sq[QN-1 -: SF+1];
    hue_d = hz ? '0 : ((HF+3)'(sec_q[QN-1]) << HF) + (HF+3)'(hfr);
    sat_d = sz ? '0 : sfr[SF] ? '1 : sfr[SF-1:0];
    val_d = mx_q[QN-1];
    usr_d = us_q[QN-1];
    vld_d = hv & sv;
  end
  hsv_div_pipe #(.N_W(CW), .D_W(CW), .Q_W(QN)) u_hue_div (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(en), .i_valid(v2_q), .i_num(num2_q), .i_den(dl2_q),
    .o_valid(hv), .o_quo(hq), .o_dz(hz)
  );
  hsv_div_pipe #(.N_W(CW), .D_W(CW), .Q_W(QN)) u_sat_div (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(en), .i_valid(v2_q), .i_num(dl2_q), .i_den(mx2_q),
    .o_valid(sv), .o_quo(sq), .o_dz(sz)
  );
  always_ff @(posedge i_clk)
    if (!i_rstn) begin
      {r1_q, g1_q, b1_q, mx1_q, mn1_q, num2_q, dl2_q, mx2_q} <= '0;
      {v1_q, v2_q, vld_q, u1_q, u2_q, usr_q, hue_q, sat_q, val_q} <= '0;
      sec1_q <= S0;
      sec2_q <= S0;
      sec_q <= '{default: S0};
      mx_q <= '{default: '0};
      us_q <= '{default: '0};
    end else if (en) begin
      {r1_q, g1_q, b1_q, mx1_q, mn1_q} <= {r1_d, g1_d, b1_d, mx1_d, mn1_d};
      {num2_q, dl2_q, mx2_q} <= {num2_d, dl2_d, mx2_d};
      {v1_q, v2_q, vld_q, u1_q, u2_q, usr_q} <= {v1_d, v2_d, vld_d, u1_d, u2_d, usr_d};
      {hue_q, sat_q, val_q} <= {hue_d, sat_d, val_d};
      sec1_q <= sec1_d;
      sec2_q <= sec2_d;
      sec_q <= sec_d;
      mx_q <= mx_d;
      us_q <= us_d;
    end
  assign o_ready = en;
  assign o_valid = vld_q;
  assign o_hue   = hue_q;
  assign o_sat   = sat_q;
  assign o_value = val_q;
  assign o_user  = usr_q;
endmodule

// File: tb/tb_hsv_stream.sv
// tb_hsv_stream: randomized and directed checks of hsv_stream against a behavioural HSV model.
module tb_hsv_stream;
  localparam int LAT = 12;
  localparam int LAT8 = 14;
  typedef struct {int h; int s; int v; int u; int acc;} exp_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic [15:0] i_data = '0;
  logic [1:0] i_user = '0, o_user;
  logic i_valid = 1'b0, o_ready, o_valid, i_ready;
  logic [10:0] o_hue;
  logic [7:0] o_sat, o_value;
  logic [23:0] d8 = '0;
  logic [1:0] u8i = '0, uo8;
  logic v8 = 1'b0, rdy8, ov8, ir8 = 1'b1;
  logic [12:0] h8;
  logic [9:0] s8;
  logic [7:0] val8;
  exp_t sb[$];
  exp_t e;
  int n_pass = 0, n_chk = 0, n_fail = 0, cyc = 0;
  int mode = 0, low_cnt = 0, mh, ms, mv;
  bit lat_on = 1'b1, prev_stall = 1'b0;
  logic [29:0] held;

  hsv_stream dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(i_data), .i_user(i_user), .i_valid(i_valid), .o_ready(o_ready),
    .o_hue(o_hue), .o_sat(o_sat), .o_value(o_value), .o_user(o_user), .o_valid(o_valid), .i_ready(i_ready)
  );
  hsv_stream #(.R_W(8), .G_W(8), .B_W(8), .CW(8), .HF(10), .SF(10), .USER_W(2)) dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_data(d8), .i_user(u8i), .i_valid(v8), .o_ready(rdy8),
    .o_hue(h8), .o_sat(s8), .o_value(val8), .o_user(uo8), .o_valid(ov8), .i_ready(ir8)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic int ex(input int x, input int w, input int cw);
    return (x * (1 << (cw - w))) + (x >> (2 * w - cw));
  endfunction

  // Straight from the colour rules: expand, pick max/min and sector, then plain integer division.
  function automatic void model(input int r0, g0, b0, rw, gw, bw, cw, hf, sf, output int h, s, v);
    int r, g, b, mx, mn, sec, num, dl;
    r = ex(r0, rw, cw);
    g = ex(g0, gw, cw);
    b = ex(b0, bw, cw);
    mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
    mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
    if (r >= g && r >= b) sec = g >= b ? 0 : 5;
    else if (g >= b) sec = r >= b ? 1 : 2;
    else sec = g >= r ? 3 : 4;
    case (sec)
      0: num = g - b;
      1: num = g - r;
      2: num = b - r;
      3: num = b - g;
      4: num = r - g;
      default: num = r - b;
    endcase
    dl = mx - mn;
    h = dl == 0 ? 0 : sec * (1 << hf) + (num * (1 << hf)) / dl;
    s = mx == 0 ? 0 : (dl * (1 << sf)) / mx;
    if (s > (1 << sf) - 1) s = (1 << sf) - 1;
    v = mx;
  endfunction

  function automatic void model565(input logic [15:0] d, output int h, s, v);
    model(int'(d[15:11]), int'(d[10:5]), int'(d[4:0]), 5, 6, 5, 8, 8, 8, h, s, v);
  endfunction

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (low_cnt > 0) begin
        i_ready = 1'b0;
        low_cnt--;
      end else i_ready = mode != 0 ? 1'($urandom % 2) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {o_valid, o_hue, o_sat, o_value, o_user}, held);
      if (o_valid && !i_ready) chk("ready_in_stall", o_ready, 0);
      if (!o_valid) chk("ready_empty", o_ready, 1);
      if (i_valid && o_ready) begin
        model565(i_data, mh, ms, mv);
        e.h = mh; e.s = ms; e.v = mv; e.u = int'(i_user); e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) chk("stale_output", o_valid, 0);
        else begin
          e = sb.pop_front();
          chk("hue", o_hue, e.h);
          chk("sat", o_sat, e.s);
          chk("value", o_value, e.v);
          chk("user", o_user, e.u);
          if (lat_on) chk("latency", cyc + 1 - e.acc, LAT);
        end
      end
      prev_stall = o_valid && !i_ready;
      held = {o_valid, o_hue, o_sat, o_value, o_user};
    end
  end

  task automatic send(input logic [15:0] d, input logic [1:0] u);
    int t;
    t = 0;
    i_data = d;
    i_user = u;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) chk("send_timeout", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h, s, v, n;
    logic [15:0] lit [7];
    int want [7][3];
    lit = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'hFFFF, 16'h0000};
    want = '{'{0, 255, 255}, '{512, 255, 255}, '{1024, 255, 255}, '{256, 255, 255},
             '{1280, 255, 255}, '{0, 0, 255}, '{0, 0, 0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_hue", o_hue, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_value", o_value, 0);
    chk("rst_user", o_user, 0);
    chk("rst_valid8", ov8, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", o_ready, 1);
    for (int i = 0; i < 7; i++) begin
      model565(lit[i], h, s, v);
      chk("model_hue", h, want[i][0]);
      chk("model_sat", s, want[i][1]);
      chk("model_value", v, want[i][2]);
    end
    model(255, 0, 0, 8, 8, 8, 8, 10, 10, h, s, v);
    chk("model8_sat", s, 1023);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(lit[i], 2'(i));
    drain();
    for (int i = 3; i < 7; i++) send(lit[i], 2'(i));
    drain();
    lat_on = 1'b0;
    mode = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) low_cnt = 10;
      send(16'($urandom), 2'($urandom));
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    mode = 0;
    drain();
    lat_on = 1'b1;
    for (int i = 0; i < 8; i++) send(16'($urandom), 2'($urandom));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    @(posedge clk);
    #1;
    send(16'h1234, 2'd1);
    drain();
    for (int i = 0; i < 65536; i++) send(16'(i), 2'(i));
    drain();
    d8 = 24'hFF0000;
    u8i = 2'd2;
    v8 = 1'b1;
    @(negedge clk);
    chk("ready8", rdy8, 1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency8", n + 1, LAT8);
    chk("hue8", h8, 0);
    chk("sat8", s8, 1023);
    chk("value8", val8, 255);
    chk("user8", uo8, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
